// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
//   - 4-bit ALU_control op-codes (shared with the ALU control decoder)
//   - pipeline-register state enum
// Optional feature macro: ALU_MUL_EN (adds the MUL op-code use and MUL state).
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_ADDI = 4'b1000;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {EMPTY, FULL, MUL} stage_state_t;
`else
  typedef enum logic [0:0] {EMPTY, FULL} stage_state_t;
`endif

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (aborts a run)
//   start          load operands a/b and begin a WIDTH-cycle run
//   a, b           operands
//   done           high during the final iteration cycle
//   product        low WIDTH bits of a*b, valid while done is high
// Used only when ALU_MUL_EN is defined.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  assign acc_next = mplier[0] ? acc + mcand : acc;
  // The last partial sum is exposed combinationally so the consumer can
  // capture it on the same edge that performs the final iteration.
  assign done     = busy && (cnt == CW'(WIDTH - 1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a one-entry valid/ready output register.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake from decode
//   ALU_control             4-bit op-code (see alu_pkg)
//   operand_a, operand_b    operands
//   out_valid / out_ready   result handshake to memory stage
//   result, zero            registered result and its zero flag
//   overflow                signed overflow on add/addi/sub
//   illegal_op              op-code not supported
// Optional feature macro: ALU_MUL_EN (op 0011 = iterative multiply).
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal_op
);

  stage_state_t state, state_next;

  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf, alu_ill;
  logic             in_fire, out_fire;
  logic             capture;
  logic [WIDTH-1:0] cap_res;
  logic             cap_ovf, cap_ill;
  logic             sub_ovf;

  assign in_ready  = (state == EMPTY) || ((state == FULL) && out_ready);
  assign out_valid = (state == FULL);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign sum     = operand_a + operand_b;
  assign diff    = operand_a - operand_b;
  assign sub_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                   (diff[WIDTH-1] != operand_a[WIDTH-1]);

`ifdef ALU_MUL_EN
  logic             op_is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign op_is_mul = (ALU_control == ALU_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (in_fire && op_is_mul),
    .a       (operand_a),
    .b       (operand_b),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // Unlisted codes (and X/Z, which match no case item) fall to default.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (ALU_control)
      ALU_AND:  alu_res = operand_a & operand_b;
      ALU_OR:   alu_res = operand_a | operand_b;
      ALU_ADD, ALU_ADDI: begin
        alu_res = sum;
        alu_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                  (sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = sub_ovf;
      end
      // Sign of the difference, corrected when the subtraction overflowed.
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
`ifdef ALU_MUL_EN
      ALU_MUL:  alu_res = '0;
`endif
      default:  alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    cap_res    = alu_res;
    cap_ovf    = alu_ovf;
    cap_ill    = alu_ill;
    case (state)
      EMPTY, FULL: begin
        if (in_fire) begin
`ifdef ALU_MUL_EN
          state_next = op_is_mul ? MUL : FULL;
          capture    = !op_is_mul;
`else
          state_next = FULL;
          capture    = 1'b1;
`endif
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        if (mul_done) begin
          state_next = FULL;
          capture    = 1'b1;
          cap_res    = mul_product;
          cap_ovf    = 1'b0;
          cap_ill    = 1'b0;
        end
      end
`endif
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      result     <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) begin
        result     <= cap_res;
        zero       <= (cap_res == '0);
        overflow   <= cap_ovf;
        illegal_op <= cap_ill;
      end
    end
  end

endmodule
